// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned DEF_ADDR_W   = 16;
   localparam int unsigned DEF_DATA_W   = 32;
   localparam int unsigned DEF_READ_LAT = 3;

   typedef enum logic {IDLE, READ} state_e;
   typedef enum logic {OWN_CORE, OWN_HOST} owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between core and host requests.
// MEM_ARB_HOST_PRIO_EN selects fixed host priority; otherwise round-robin on last.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic   core_req,
   input  logic   host_req,
   input  owner_e last,
   output owner_e winner,
   output logic   valid
);

`ifdef MEM_ARB_HOST_PRIO_EN
   logic unused_last;
   assign unused_last = last;

   always_comb begin
      valid  = core_req | host_req;
      winner = host_req ? OWN_HOST : OWN_CORE;
   end
`else
   always_comb begin
      valid  = core_req | host_req;
      winner = OWN_CORE;
      if (core_req && host_req) begin
         // On a conflict, the requester not served last time wins.
         winner = (last == OWN_HOST) ? OWN_CORE : OWN_HOST;
      end else if (host_req) begin
         winner = OWN_HOST;
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported memory between core and host, hiding the fixed read latency
// behind req/gnt/rvalid. Arbitration mode is chosen by MEM_ARB_HOST_PRIO_EN in mem_arb_pick.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned DATA_W   = DEF_DATA_W,
   parameter int unsigned READ_LAT = DEF_READ_LAT  // legal range 1..15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              busy,
   output logic              mem_en,
   output logic              mem_ren,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   localparam logic [3:0] LAT_CNT = 4'(READ_LAT);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   owner_e            owner_q, owner_d;
   owner_e            last_q, last_d;
   logic              en_q, en_d, ren_q, ren_d, wen_q, wen_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] din_q, din_d;
   logic              core_gnt_q, core_gnt_d, host_gnt_q, host_gnt_d;
   logic              core_rvalid_q, core_rvalid_d, host_rvalid_q, host_rvalid_d;
   logic [DATA_W-1:0] core_rdata_q, core_rdata_d, host_rdata_q, host_rdata_d;

   owner_e            winner;
   logic              pick_valid;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   mem_arb_pick u_pick (
      .core_req (core_req),
      .host_req (host_req),
      .last     (last_q),
      .winner   (winner),
      .valid    (pick_valid)
   );

   assign sel_we    = (winner == OWN_HOST) ? host_we    : core_we;
   assign sel_addr  = (winner == OWN_HOST) ? host_addr  : core_addr;
   assign sel_wdata = (winner == OWN_HOST) ? host_wdata : core_wdata;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      owner_d       = owner_q;
      last_d        = last_q;
      en_d          = 1'b0;
      ren_d         = 1'b0;
      wen_d         = 1'b0;
      addr_d        = addr_q;
      din_d         = din_q;
      core_gnt_d    = 1'b0;
      host_gnt_d    = 1'b0;
      core_rvalid_d = 1'b0;
      host_rvalid_d = 1'b0;
      core_rdata_d  = core_rdata_q;
      host_rdata_d  = host_rdata_q;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               en_d   = 1'b1;
               wen_d  = sel_we;
               ren_d  = ~sel_we;
               addr_d = sel_addr;
               din_d  = sel_wdata;
               last_d = winner;
               if (winner == OWN_HOST) host_gnt_d = 1'b1;
               else                    core_gnt_d = 1'b1;
               // Writes complete in one cycle, so only reads leave IDLE.
               if (!sel_we) begin
                  state_d = READ;
                  cnt_d   = 4'd1;
                  owner_d = winner;
               end
            end
         end
         READ: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAT_CNT) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
               if (owner_q == OWN_HOST) begin
                  host_rdata_d  = mem_dout;
                  host_rvalid_d = 1'b1;
               end else begin
                  core_rdata_d  = mem_dout;
                  core_rvalid_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         owner_q       <= OWN_CORE;
         last_q        <= OWN_HOST;
         en_q          <= 1'b0;
         ren_q         <= 1'b0;
         wen_q         <= 1'b0;
         addr_q        <= '0;
         din_q         <= '0;
         core_gnt_q    <= 1'b0;
         host_gnt_q    <= 1'b0;
         core_rvalid_q <= 1'b0;
         host_rvalid_q <= 1'b0;
         core_rdata_q  <= '0;
         host_rdata_q  <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         owner_q       <= owner_d;
         last_q        <= last_d;
         en_q          <= en_d;
         ren_q         <= ren_d;
         wen_q         <= wen_d;
         addr_q        <= addr_d;
         din_q         <= din_d;
         core_gnt_q    <= core_gnt_d;
         host_gnt_q    <= host_gnt_d;
         core_rvalid_q <= core_rvalid_d;
         host_rvalid_q <= host_rvalid_d;
         core_rdata_q  <= core_rdata_d;
         host_rdata_q  <= host_rdata_d;
      end
   end

   assign busy        = (state_q == READ);
   assign mem_en      = en_q;
   assign mem_ren     = ren_q;
   assign mem_wen     = wen_q;
   assign mem_addr    = addr_q;
   assign mem_din     = din_q;
   assign core_gnt    = core_gnt_q;
   assign host_gnt    = host_gnt_q;
   assign core_rvalid = core_rvalid_q;
   assign host_rvalid = host_rvalid_q;
   assign core_rdata  = core_rdata_q;
   assign host_rdata  = host_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural synchronous memory.
// Expected conflict winners follow MEM_ARB_HOST_PRIO_EN when it is defined.
module tb_mem_port_arbiter;

   localparam int unsigned READ_LAT = 3;
`ifdef MEM_ARB_HOST_PRIO_EN
   localparam bit HOST_PRIO = 1'b1;
`else
   localparam bit HOST_PRIO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_req, core_we, host_req, host_we;
   logic [15:0] core_addr, host_addr, mem_addr;
   logic [31:0] core_wdata, host_wdata, mem_din, mem_dout;
   logic        core_gnt, core_rvalid, host_gnt, host_rvalid, busy;
   logic [31:0] core_rdata, host_rdata;
   logic        mem_en, mem_ren, mem_wen;

   mem_port_arbiter #(
      .ADDR_W   (16),
      .DATA_W   (32),
      .READ_LAT (READ_LAT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .core_req    (core_req),
      .core_we     (core_we),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .core_gnt    (core_gnt),
      .core_rvalid (core_rvalid),
      .core_rdata  (core_rdata),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_gnt    (host_gnt),
      .host_rvalid (host_rvalid),
      .host_rdata  (host_rdata),
      .busy        (busy),
      .mem_en      (mem_en),
      .mem_ren     (mem_ren),
      .mem_wen     (mem_wen),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din),
      .mem_dout    (mem_dout)
   );

   always #5 clk = ~clk;

   logic [31:0] ram [0:65535];
   always @(posedge clk) begin
      if (mem_en && mem_wen) ram[mem_addr] <= mem_din;
      if (mem_en && mem_ren) mem_dout <= ram[mem_addr];
   end

   function automatic logic [31:0] pattern(input logic [15:0] a);
      return {~a, a};
   endfunction

   int passed = 0;
   int total  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail(input string name);
      total++;
      $display("FAIL %s: protocol event got 1 expected 0", name);
   endtask

   // Scoreboard: expected read data per requester, in issue order.
   logic [31:0] core_q[$];
   logic [31:0] host_q[$];
   int ncyc = 0, core_gnt_cyc = 0, host_gnt_cyc = 0, core_rv_cyc = 0, rv_count = 0;

   always @(negedge clk) begin
      logic [31:0] e;
      ncyc++;
      if (core_gnt) core_gnt_cyc = ncyc;
      if (host_gnt) host_gnt_cyc = ncyc;
      if (core_gnt && core_rvalid) fail("core_gnt_rvalid_overlap");
      if (host_gnt && host_rvalid) fail("host_gnt_rvalid_overlap");
      if (core_rvalid) begin
         rv_count++;
         core_rv_cyc = ncyc;
         if (core_q.size() == 0) fail("core_rvalid_unexpected");
         else begin
            e = core_q.pop_front();
            check("core_rdata", core_rdata, e);
            check("core_rvalid_lat", ncyc - core_gnt_cyc, READ_LAT);
         end
      end
      if (host_rvalid) begin
         rv_count++;
         if (host_q.size() == 0) fail("host_rvalid_unexpected");
         else begin
            e = host_q.pop_front();
            check("host_rdata", host_rdata, e);
            check("host_rvalid_lat", ncyc - host_gnt_cyc, READ_LAT);
         end
      end
   end

   function automatic logic [127:0] all_outs();
      return {core_gnt, host_gnt, core_rvalid, host_rvalid, busy, mem_en, mem_ren, mem_wen,
              mem_addr, mem_din, core_rdata, host_rdata};
   endfunction

   task automatic issue(input bit who, input bit we, input logic [15:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input int exp_wait, input string name);
      int n;
      bit got;
      if (!who) begin
         core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wdata;
         if (!we) core_q.push_back(exp_rd);
      end else begin
         host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wdata;
         if (!we) host_q.push_back(exp_rd);
      end
      n = 0;
      got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         got = who ? host_gnt : core_gnt;
      end
      if (!who) core_req = 1'b0;
      else      host_req = 1'b0;
      check({name, "_wait"}, n, exp_wait);
      if (got)
         check({name, "_mem"}, {mem_en, mem_wen, mem_ren, mem_addr, (we ? mem_din : 32'h0)},
               {1'b1, we, !we, addr, (we ? wdata : 32'h0)});
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      core_req = 1'b0;
      host_req = 1'b0;
      @(negedge clk);
      check("reset_outputs", all_outs(), 128'h0);
      @(negedge clk);
      core_q.delete();
      host_q.delete();
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((core_q.size() + host_q.size()) != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check({name, "_drain"}, core_q.size() + host_q.size(), 0);
   endtask

   typedef struct {
      bit          who;
      bit          we;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      int          exp_wait;
   } vec_t;

   vec_t vecs[10];
   bit   order[8];
   bit   exp_order[8];
   int   cn, hn, k, rv_before;

   initial begin
      rst_n = 1'b0;
      core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
      host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
      mem_dout = '0;
      for (int i = 0; i < 65536; i++) ram[i] = pattern(16'(i));
      ram[16'h0004] = 32'h12345678;

      // who: 0 core, 1 host. A request after a read waits READ_LAT+1 cycles for gnt.
      vecs[0] = '{0, 0, 16'h0004, 32'h0,        32'h12345678,     1};
      vecs[1] = '{1, 1, 16'h0100, 32'hDEADBEEF, 32'h0,            READ_LAT + 1};
      vecs[2] = '{1, 1, 16'h0101, 32'hDEADBEEF, 32'h0,            1};
      vecs[3] = '{1, 1, 16'h0102, 32'hDEADBEEF, 32'h0,            1};
      vecs[4] = '{1, 0, 16'h0101, 32'h0,        32'hDEADBEEF,     1};
      vecs[5] = '{0, 0, 16'h0102, 32'h0,        32'hDEADBEEF,     READ_LAT + 1};
      vecs[6] = '{0, 1, 16'h0200, 32'hCAFEF00D, 32'h0,            READ_LAT + 1};
      vecs[7] = '{1, 0, 16'h0200, 32'h0,        32'hCAFEF00D,     1};
      vecs[8] = '{0, 0, 16'h3000, 32'h0,        pattern(16'h3000), READ_LAT + 1};
      vecs[9] = '{1, 0, 16'hFFFF, 32'h0,        pattern(16'hFFFF), READ_LAT + 1};

      repeat (3) @(negedge clk);
      check("reset_state", all_outs(), 128'h0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd,
               vecs[i].exp_wait, $sformatf("vec%0d", i));
         if (i == 1) check("host_quiet", {host_rvalid, host_rdata}, 33'h0);
      end
      drain("table");

      // Host request during a core read is held until after the capture edge.
      issue(0, 0, 16'h0004, 32'h0, 32'h12345678, 1, "core_rd");
      issue(1, 0, 16'h0100, 32'h0, 32'hDEADBEEF, READ_LAT + 1, "host_held");
      #1;
      check("host_gnt_after_capture", host_gnt_cyc - core_rv_cyc, 1);
      drain("held");

      // Both requesters read continuously from reset.
      do_reset();
      for (int i = 0; i < 8; i++) exp_order[i] = HOST_PRIO ? (i < 4) : i[0];
      cn = 0; hn = 0; k = 0;
      core_we = 1'b0; core_addr = 16'h2000; core_req = 1'b1;
      host_we = 1'b0; host_addr = 16'h2800; host_req = 1'b1;
      for (int t = 0; t < 100 && k < 8; t++) begin
         @(negedge clk);
         if (core_gnt && k < 8) begin
            order[k] = 1'b0; k++;
            core_q.push_back(pattern(core_addr));
            cn++; core_addr++;
            if (cn == 4) core_req = 1'b0;
         end
         if (host_gnt && k < 8) begin
            order[k] = 1'b1; k++;
            host_q.push_back(pattern(host_addr));
            hn++; host_addr++;
            if (hn == 4) host_req = 1'b0;
         end
      end
      core_req = 1'b0;
      host_req = 1'b0;
      check("alt_grant_count", k, 8);
      for (int i = 0; i < k; i++) check($sformatf("alt_order%0d", i), order[i], exp_order[i]);
      drain("alt");

      // Reset in the second cycle of a read aborts it; first conflict afterwards.
      issue(0, 0, 16'h3000, 32'h0, pattern(16'h3000), 1, "abort_rd");
      rv_before = rv_count;
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_outputs", all_outs(), 128'h0);
      core_q.delete();
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("abort_no_rvalid", rv_count - rv_before, 0);
      core_we = 1'b1; core_addr = 16'h0300; core_wdata = 32'h11111111; core_req = 1'b1;
      host_we = 1'b1; host_addr = 16'h0301; host_wdata = 32'h22222222; host_req = 1'b1;
      k = 0;
      while (!(core_gnt || host_gnt) && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("post_reset_conflict", {core_gnt, host_gnt}, HOST_PRIO ? 2'b01 : 2'b10);
      core_req = 1'b0;
      host_req = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer for the single-ported instruction/data memory. It shares the memory between two requesters: the CPU control path (fetch, load, store) and the host inference/debug port that reads result memory. The block owns the memory's enable, read-enable, write-enable, address and write-data lines. It hides the fixed read latency behind a request/grant/read-valid handshake, so that requesters no longer need to count wait states themselves.

## Interface
Parameters:
- ADDR_W, 16, memory address width
- DATA_W, 32, memory data width
- READ_LAT, 3, number of clock edges from the issue edge to the edge that captures valid mem_dout; legal range 1..15

Ports:
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- core_req / host_req  in  1  access request; held with addr/we/wdata stable until the matching gnt
- core_we / host_we  in  1  1 = write, 0 = read
- core_addr / host_addr  in  ADDR_W  access address
- core_wdata / host_wdata  in  DATA_W  write data
- core_gnt / host_gnt  out  1  one-cycle pulse: request accepted and issued to memory
- core_rvalid / host_rvalid  out  1  one-cycle pulse: read data valid
- core_rdata / host_rdata  out  DATA_W  read data; holds its last value between reads
- busy  out  1  high while a read is in flight
- mem_en, mem_ren, mem_wen  out  1  memory controls
- mem_addr  out  ADDR_W  memory address
- mem_din  out  DATA_W  memory write data
- mem_dout  in  DATA_W  memory read data

## Operation
- States: IDLE and READ. A 4-bit latency counter, cnt, is used in READ. An owner register records the requester of the access in flight, and a last register records the most recently granted requester.
- IDLE, no request pending: all mem_* controls are 0; mem_addr and mem_din hold their values.
- IDLE, with a request pending, at the next edge:
  - select the winner;
  - register mem_en=1, mem_addr and mem_din from the winner;
  - set mem_wen=we and mem_ren=~we;
  - pulse the winner's gnt;
  - update last.
- Write: the block stays in IDLE. A new request can therefore be issued at the very next edge; mem_en stays 1 across back-to-back issues.
- Read: the block moves to READ with cnt=1 and owner set to the winner. mem_en and mem_ren drop at the edge after issue.
- READ: cnt increments on each edge. At the edge where cnt==READ_LAT:
  - capture mem_dout into the owner's rdata;
  - pulse the owner's rvalid;
  - return to IDLE.
- No arbitration takes place on the capture edge; the next issue can happen at the following edge.
- Requests that arrive during READ are held off: no gnt is given. The requester keeps req high.
- Arbitration is round-robin. When both requests are high, the winner is the requester that is not in last. When only one request is high, it wins.
- Reset sets every output to 0, including rdata. The block goes to IDLE with cnt=0 and last=host, so the core wins the first conflict.
- Reset during READ aborts the access; no rvalid is produced.

## Timing
- Requests are sampled at edge E. gnt is high in cycle E..E+1, and memory sees the access at edge E+1.
- Read data is captured at edge E+READ_LAT, and rvalid/rdata are high in the cycle that follows. The read-to-read issue period is READ_LAT+1 edges.
- Write throughput is one write per cycle.
- gnt and rvalid for the same requester are never high in the same cycle.
- busy is high from edge E to edge E+READ_LAT, exclusive of the capture edge.

## Configuration
- MEM_ARB_HOST_PRIO_EN defined: the host has fixed priority. When both requests are high, the host always wins; the last register is unused.
- MEM_ARB_HOST_PRIO_EN undefined: round-robin arbitration, as described under Operation.

## Structure
- Package mem_arb_pkg contains:
  - the state enum {IDLE, READ};
  - the owner enum {OWN_CORE, OWN_HOST};
  - the default ADDR_W, DATA_W and READ_LAT constants.
- Sub-module mem_arb_pick is a combinational winner-select: inputs core_req, host_req and last, output winner plus a valid flag. The MEM_ARB_HOST_PRIO_EN switch lives only inside this sub-module.

## Test plan
- Core read alone, READ_LAT=3, memory preloaded with 0x12345678 at 0x0004, request at edge 10 -> core_gnt pulses in cycle 10; core_rvalid pulses in cycle 13 with core_rdata=0x12345678; host outputs stay 0.
- Host writes 0xDEADBEEF to 0x0100, 0x0101 and 0x0102 back-to-back -> three consecutive gnt pulses, mem_wen high for three cycles, and a later read of 0x0101 returns 0xDEADBEEF.
- Both requesters read continuously from reset -> grants alternate core, host, core, host; each rvalid goes to the correct owner with its own address's data.
- Host requests during a core READ -> no host_gnt until the cycle after the core capture edge, then host_gnt; host_req must stay asserted throughout.
- With MEM_ARB_HOST_PRIO_EN, simultaneous requests on four occasions -> the host wins all four, and the core is granted only when host_req is low.
- rst_n asserted low in cycle 2 of READ -> no rvalid is produced, all outputs read 0 next cycle, and the first post-reset conflict is won by the core (round-robin build).
